fft_out_serializer: RTL
=======================

Name: fft_out_serializer

Overview:
- Consumer end of the FFT core's parallel output interface: a frame arrives as N complex bins in one cycle, qualified by the valid and mode flags.
- Captures each frame into a ping-pong frame buffer.
- Re-streams the frame one bin per cycle on a valid/ready interface, with a last-beat marker, for downstream demod/file-dump logic.
- Lets the FFT core deliver frame k+1 while frame k is still draining.

Parameters:
- N, 32, FFT size (bins per frame); power of 2, at least 4.
- DROP_W, 16, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable; when low, in_valid is ignored
- fft_in  in  N x complex_product_t (N*64)  parallel FFT bins; index 0 is bin 0
- in_valid  in  1  fft_in/in_mode valid this cycle
- in_mode  in  1  stream tag from the FFT core (0 = stream 0, 1 = stream 1)
- data_out  out  complex_product_t (64)  serialized bin, .r and .i each 32-bit signed
- out_mode  out  1  stream tag of the frame being streamed
- out_idx  out  log2(N)  bin index of data_out
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accept
- out_last  out  1  high with the bin at out_idx == N-1
- frame_drop  out  1  one-cycle pulse when an offered frame is dropped
- drop_count  out  DROP_W  saturating count of dropped frames

Behaviour:
- Reset state:
  - data_out = 0, out_mode = 0, out_idx = 0.
  - out_valid, out_last and frame_drop = 0; drop_count = 0.
  - Both buffers EMPTY; wr_sel = 0, rd_sel = 0.
- A reset asserted mid-frame discards both buffers immediately; no partial frame is emitted.
- Buffer state: per buffer b, full[b] and mode[b].
- Capture (at edge t):
  - Happens when enable && in_valid and buffer wr_sel is EMPTY, or it is being released at this edge (last-beat handshake).
  - Writes all N bins and in_mode into buffer wr_sel, sets full, and toggles wr_sel.
- Drop:
  - Happens when enable && in_valid and the capture condition fails.
  - Frame is discarded; frame_drop pulses for one cycle.
  - drop_count increments and saturates at 2^DROP_W-1. The buffer contents are untouched.
- Reader FSM: IDLE, STREAM.
  - IDLE: if full[rd_sel], go to STREAM and present bin 0 with out_mode = mode[rd_sel].
  - STREAM: out_valid = 1.
  - On out_valid && out_ready: out_idx increments.
  - On the beat with out_idx == N-1 (out_last = 1): clear full[rd_sel] and toggle rd_sel.
    - If the other buffer is full, continue STREAM at bin 0 of that buffer with no bubble.
    - Otherwise go to IDLE.
- Latency: a frame captured at edge t into an empty block (IDLE) gives out_valid = 1 with bin 0 after edge t+1, i.e. one register stage.
- Stall: while out_valid && !out_ready, data_out, out_idx, out_last and out_mode are held stable.
- Full throughput: with out_ready tied high, N beats per frame. Frames spaced N or more cycles apart never drop.
- Capture into buffer wr_sel never disturbs the bins being read from buffer rd_sel.
- enable low: blocks capture only; streaming continues.
- Data is passed through unmodified; no arithmetic and no width change.

Optional Feature:
- FFT_SER_BITREV_EN defined:
  - Read address is bit_reverse(out_idx) over log2(N) bits, so a bit-reversed-order FFT output emerges in natural order.
  - out_idx still counts 0..N-1 and reports the natural bin number.
- Not defined: the read address equals out_idx.

Decomposition:
- Shared package / src/headers.svh:
  - complex_product_t, already shared with the FFT core.
  - FFT_SER_IDX_W = $clog2(N) as a localparam.
  - A bit_reverse function used by this block and the FFT core.
- One sub-module, fft_ser_frame_buf:
  - A single N-entry frame register plus full/mode flags.
  - Parallel write port and indexed read port.
  - Instantiated twice for ping/pong.

Test Plan:
1. Reset, then one frame with N=32, fft_in[j] = {r=j, i=-j}, in_mode = 0, out_ready = 1.
   - out_valid rises one cycle after capture; 32 beats with r = 0..31, i = 0..-31.
   - out_last only on beat 31, then out_valid = 0.
2. Back-to-back frames A (in_mode = 0) and B (in_mode = 1) offered 1 cycle apart.
   - Both captured; 64 contiguous beats, no bubble.
   - out_mode switches 0 to 1 at beat 32; drop_count = 0.
3. Frames A, B, C offered on consecutive cycles with out_ready = 0.
   - C dropped; frame_drop pulses once; drop_count = 1.
   - After releasing out_ready, A then B stream intact.
4. out_ready toggled 1,0,0,1 during streaming.
   - data_out/out_idx held during the low cycles; no bin lost or duplicated.
5. Both buffers full; frame C offered on the cycle of A's last handshake.
   - C is accepted, no drop; the output order is A, B, C.
6. Reset asserted at beat 10 of a frame.
   - Next cycle out_valid = 0, drop_count = 0.
   - A new frame afterwards streams from bin 0.
   - With FFT_SER_BITREV_EN: input bin j holds bitrev(j); output r = 0..31 in order.

Source files
------------

// File: rtl/fft_out_serializer_pkg.sv
// fft_out_serializer_pkg
//   Types and helpers shared between the FFT core and its output serializer.
//   complex_product_t : one complex bin, 32-bit signed real/imag.
//   FFT_SER_N         : default FFT size.
//   FFT_SER_IDX_W     : bin index width for the default FFT size.
//   bit_reverse()     : reverses the low w bits of v (w <= 16).
//   ser_state_e       : reader FSM states.
package fft_out_serializer_pkg;

  localparam int FFT_SER_N     = 32;
  localparam int FFT_SER_IDX_W = $clog2(FFT_SER_N);

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } ser_state_e;

  function automatic logic [15:0] bit_reverse(input logic [15:0] v, input int w);
    logic [15:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < w) res[w-1-k] = v[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// fft_out_serializer_if
//   Bundles the parallel FFT input side and the serialized valid/ready output
//   side of fft_out_serializer.
//   slave  : serializer view (consumes fft_in, produces data_out stream).
//   master : producer/consumer environment view.
import fft_out_serializer_pkg::*;

interface fft_out_serializer_if #(
  parameter int N      = FFT_SER_N,
  parameter int DROP_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic                       enable;
  complex_product_t [N-1:0]   fft_in;
  logic                       in_valid;
  logic                       in_mode;
  complex_product_t           data_out;
  logic                       out_mode;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       frame_drop;
  logic [DROP_W-1:0]          drop_count;

  modport slave (
    input  enable, fft_in, in_valid, in_mode, out_ready,
    output data_out, out_mode, out_idx, out_valid, out_last, frame_drop, drop_count
  );

  modport master (
    output enable, fft_in, in_valid, in_mode, out_ready,
    input  data_out, out_mode, out_idx, out_valid, out_last, frame_drop, drop_count
  );

endinterface

// File: rtl/fft_ser_frame_buf.sv
// fft_ser_frame_buf
//   One N-bin frame register with full/mode flags: parallel write, indexed read.
//   clk, reset : system clock, synchronous active-high reset (clears full/mode)
//   wr_en      : load wr_bins/wr_mode and set full
//   clr        : release the frame (clear full); wr_en wins on the same edge
//   rd_addr    : bin read address; rd_data is combinational
//   full, mode : buffer holds a frame / stream tag of that frame
import fft_out_serializer_pkg::*;

module fft_ser_frame_buf #(
  parameter int N     = FFT_SER_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  complex_product_t [N-1:0] wr_bins,
  input  logic                     wr_mode,
  input  logic                     clr,
  input  logic [IDX_W-1:0]         rd_addr,
  output complex_product_t         rd_data,
  output logic                     full,
  output logic                     mode
);

  complex_product_t [N-1:0] bins_q, bins_d;
  logic full_q, full_d, mode_q, mode_d;

  always_comb begin
    bins_d = bins_q;
    full_d = full_q;
    mode_d = mode_q;
    if (clr) full_d = 1'b0;
    // A refill on the release edge keeps the buffer full with the new frame.
    if (wr_en) begin
      bins_d = wr_bins;
      full_d = 1'b1;
      mode_d = wr_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      full_q <= full_d;
      mode_q <= mode_d;
    end
  end

  // Bin storage is data only; validity lives in full_q.
  always_ff @(posedge clk) begin
    bins_q <= bins_d;
  end

  assign rd_data = bins_q[rd_addr];
  assign full    = full_q;
  assign mode    = mode_q;

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//   Captures parallel FFT frames into a ping/pong pair of frame buffers and
//   re-streams each frame one bin per cycle on a valid/ready port, with a
//   last-beat marker. A new frame may land while the previous one drains.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : fft_out_serializer_if.slave (enable, fft_in, in_valid, in_mode,
//           data_out, out_mode, out_idx, out_valid, out_ready, out_last,
//           frame_drop, drop_count)
//   Optional: define FFT_SER_BITREV_EN to read bins at bit_reverse(out_idx),
//   turning a bit-reversed FFT output into natural order.
import fft_out_serializer_pkg::*;

module fft_out_serializer #(
  parameter int N      = FFT_SER_N,
  parameter int DROP_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_out_serializer_if.slave  bus
);

  localparam int IDX_W = $clog2(N);

  ser_state_e        state_q, state_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  complex_product_t  data_out_q, data_out_d;
  logic              out_mode_q, out_mode_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_drop_q, frame_drop_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  complex_product_t  buf_rd [2];
  logic [1:0]        buf_full, buf_mode, buf_wr, buf_clr;
  logic [IDX_W-1:0]  nxt_idx, rd_addr;
  logic              fire, rel, offer, cap_ok, capture;

  assign fire    = out_valid_q && bus.out_ready;
  assign rel     = fire && out_last_q;
  assign offer   = bus.enable && bus.in_valid;
  // The write target may be the buffer whose last beat is handshaking now.
  assign cap_ok  = !buf_full[wr_sel_q] || (rel && (rd_sel_q == wr_sel_q));
  assign capture = offer && cap_ok;

  // Bin to present after this edge: next bin of the current frame, else bin 0
  // (of the same buffer from IDLE, or of the other buffer on a hand-over).
  assign nxt_idx = (state_q == S_STREAM && fire && !out_last_q) ? out_idx_q + 1'b1 : '0;

`ifdef FFT_SER_BITREV_EN
  assign rd_addr = IDX_W'(bit_reverse(16'(nxt_idx), IDX_W));
`else
  assign rd_addr = nxt_idx;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_buf
    assign buf_wr[b]  = capture && (wr_sel_q == 1'(b));
    assign buf_clr[b] = rel && (rd_sel_q == 1'(b));

    fft_ser_frame_buf #(.N(N), .IDX_W(IDX_W)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr[b]),
      .wr_bins (bus.fft_in),
      .wr_mode (bus.in_mode),
      .clr     (buf_clr[b]),
      .rd_addr (rd_addr),
      .rd_data (buf_rd[b]),
      .full    (buf_full[b]),
      .mode    (buf_mode[b])
    );
  end

  always_comb begin
    state_d      = state_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    data_out_d   = data_out_q;
    out_mode_d   = out_mode_q;
    out_idx_d    = out_idx_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_drop_d = 1'b0;
    drop_count_d = drop_count_q;

    if (capture) wr_sel_d = ~wr_sel_q;
    if (offer && !cap_ok) begin
      frame_drop_d = 1'b1;
      if (drop_count_q != {DROP_W{1'b1}}) drop_count_d = drop_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full[rd_sel_q]) begin
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_last_d  = 1'b0;
          data_out_d  = buf_rd[rd_sel_q];
          out_mode_d  = buf_mode[rd_sel_q];
        end
      end
      S_STREAM: begin
        if (fire) begin
          if (out_last_q) begin
            rd_sel_d   = ~rd_sel_q;
            out_idx_d  = '0;
            out_last_d = 1'b0;
            if (buf_full[~rd_sel_q]) begin
              // Hand over to the other buffer with no bubble.
              data_out_d = buf_rd[~rd_sel_q];
              out_mode_d = buf_mode[~rd_sel_q];
            end else begin
              state_d     = S_IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            out_idx_d  = nxt_idx;
            out_last_d = (nxt_idx == IDX_W'(N-1));
            data_out_d = buf_rd[rd_sel_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      data_out_q   <= '0;
      out_mode_q   <= 1'b0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      data_out_q   <= data_out_d;
      out_mode_q   <= out_mode_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_drop_q <= frame_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_drop = frame_drop_q;
  assign bus.drop_count = drop_count_q;

endmodule
